// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation engine:
// legal width range and the sequencer state encoding.
package rsa_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [2:0] {
    IDLE,
    PRE_M,
    PRE_X,
    SQUARE,
    MULT,
    POST,
    DONE
  } state_t;

  // States in which a Montgomery multiplication is in flight
  function automatic logic is_compute(input state_t s);
    return (s == PRE_M) || (s == PRE_X) || (s == SQUARE) || (s == MULT) || (s == POST);
  endfunction

endpackage

// File: rtl/mont_mult.sv
// Radix-2 Montgomery multiplier: R = A*B*2^-WIDTH mod P in WIDTH+1 cycles.
// The start cycle already consumes bit 0 of A; the final cycle is the conditional subtract.
module mont_mult #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] P,
  output logic             done,
  output logic [WIDTH-1:0] R
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH+1:0] t;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] p_op;
  logic [CW-1:0]    cnt;
  logic             active;

  logic [WIDTH+1:0] t_in;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] t_step;
  logic [WIDTH+1:0] t_sub;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] p_sel;
  logic             a_bit;

  // One accumulate/halve step; on start the operands come straight from the ports with T=0
  always_comb begin
    t_in  = start ? '0 : t;
    a_bit = start ? A[0] : a_sh[0];
    b_sel = start ? B : b_op;
    p_sel = start ? P : p_op;
    sum   = t_in + (a_bit ? {2'b00, b_sel} : '0);
    if (sum[0]) begin
      sum = sum + {2'b00, p_sel};
    end
    t_step = sum >> 1;
    t_sub  = t - {2'b00, p_op};
    done   = active && (cnt == CW'(WIDTH));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      t      <= '0;
      a_sh   <= '0;
      b_op   <= '0;
      p_op   <= '0;
      cnt    <= '0;
      active <= 1'b0;
      R      <= '0;
    end else if (ena) begin
      if (abort) begin
        active <= 1'b0;
      end else if (start) begin
        t      <= t_step;
        a_sh   <= A >> 1;
        b_op   <= B;
        p_op   <= P;
        cnt    <= CW'(1);
        active <= 1'b1;
      end else if (active) begin
        if (cnt == CW'(WIDTH)) begin
          R      <= (t >= {2'b00, p_op}) ? t_sub[WIDTH-1:0] : t[WIDTH-1:0];
          active <= 1'b0;
        end else begin
          t    <= t_step;
          a_sh <= a_sh >> 1;
          cnt  <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rsa_modexp_engine.sv
// Computes C = M^E mod P by left-to-right square-and-multiply in the Montgomery
// domain, sequencing a single shared mont_mult instance.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_clr,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] Const,
  output logic [WIDTH-1:0] C,
  output logic             busy,
  output logic             eoc,
  output logic             err,
  output logic             irq
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, state_next;

  logic [WIDTH-1:0] p_reg, e_reg, cst_reg, mbar, c_reg, c_done;
  logic [IW-1:0]    idx;
  logic             err_reg, irq_reg, mm_go;
  logic             bad_ops;

  logic             mm_start, mm_abort, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p, mm_r;

  assign bad_ops  = !P[0] || (P < WIDTH'(3)) || (M >= P);
  assign mm_abort = ena && stop && is_compute(state);

  mont_mult #(.WIDTH(WIDTH)) u_mm (
    .clk   (clk),
    .rstb  (rstb),
    .ena   (ena),
    .start (mm_start),
    .abort (mm_abort),
    .A     (mm_a),
    .B     (mm_b),
    .P     (mm_p),
    .done  (mm_done),
    .R     (mm_r)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  // Exponent bits are consumed MSB first; a 1 bit adds a MULT after its SQUARE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !stop) state_next = bad_ops ? DONE : PRE_M;
      PRE_M:   if (mm_done) state_next = PRE_X;
      PRE_X:   if (mm_done) state_next = SQUARE;
      SQUARE:  if (mm_done) state_next = e_reg[idx] ? MULT : ((idx == '0) ? POST : SQUARE);
      MULT:    if (mm_done) state_next = (idx == '0) ? POST : SQUARE;
      POST:    if (mm_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (stop && is_compute(state)) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    mm_start = 1'b0;
    mm_a     = mm_r;
    mm_b     = mm_r;
    mm_p     = p_reg;
    case (state)
      IDLE: begin
        mm_start = ena && start && !stop && !bad_ops;
        mm_a     = M;
        mm_b     = Const;
        mm_p     = P;
      end
      PRE_X: begin
        mm_start = ena && mm_go && !stop;
        mm_a     = WIDTH'(1);
        mm_b     = cst_reg;
      end
      SQUARE:  mm_start = ena && mm_go && !stop;
      MULT: begin
        mm_start = ena && mm_go && !stop;
        mm_b     = mbar;
      end
      POST: begin
        mm_start = ena && mm_go && !stop;
        mm_b     = WIDTH'(1);
      end
      default: ;
    endcase
    c_done = err_reg ? '0 : mm_r;
    busy   = (state != IDLE);
    eoc    = ena && (state == DONE);
    err    = err_reg;
    irq    = irq_reg;
    C      = (state == DONE) ? c_done : c_reg;
  end

  // Job operands and bookkeeping; Mbar is captured once PRE_M's result has settled in mm_r
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p_reg   <= '0;
      e_reg   <= '0;
      cst_reg <= '0;
      mbar    <= '0;
      c_reg   <= '0;
      idx     <= '0;
      err_reg <= 1'b0;
      irq_reg <= 1'b0;
      mm_go   <= 1'b0;
    end else if (ena) begin
      mm_go <= mm_done && is_compute(state_next);
      if (state == IDLE && start && !stop) begin
        p_reg   <= P;
        e_reg   <= E;
        cst_reg <= Const;
        idx     <= IW'(WIDTH - 1);
        if (bad_ops) begin
          err_reg <= 1'b1;
        end
      end
      if (state == PRE_X && mm_go) begin
        mbar <= mm_r;
      end
      if (mm_done && idx != '0 && ((state == SQUARE && !e_reg[idx]) || state == MULT)) begin
        idx <= idx - IW'(1);
      end
      if (state == POST && state_next == DONE) begin
        err_reg <= 1'b0;
      end
      if (state == DONE) begin
        c_reg <= c_done;
      end
      if (state_next == DONE && state != DONE) begin
        irq_reg <= 1'b1;
      end else if (irq_clr) begin
        irq_reg <= 1'b0;
      end
    end
  end

endmodule
